// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and widths for the instruction cache
//
// Purpose: refill FSM state encoding and the fixed datapath widths used by
// instruction_cache and icache_data_array.
// Ports: none (package).
// Optional build macro used by this block: ICACHE_PERF_COUNTERS_EN.

package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    localparam int BLOCK_BITS    = 128;
    localparam int WORD_BITS     = 32;
    localparam int MEM_ADDR_BITS = 28;
    localparam int OFFSET_BITS   = 2;

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - flop-based valid/tag/data storage for the instruction cache
//
// Purpose: one valid bit, one tag and one 128-bit block per line. Only the
// valid bits are reset; tags and data keep whatever they held.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   read_index          line looked up combinationally
//   write_enable        fill the line at write_index on the next edge
//   write_index         line being filled
//   write_tag           tag stored with the fill
//   write_block         128-bit block stored with the fill
//   valid, tag, block   contents of the line at read_index

import icache_pkg::*;

module icache_data_array #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] read_index,
    input  logic                  write_enable,
    input  logic [INDEX_BITS-1:0] write_index,
    input  logic [TAG_BITS-1:0]   write_tag,
    input  logic [BLOCK_BITS-1:0] write_block,
    output logic                  valid,
    output logic [TAG_BITS-1:0]   tag,
    output logic [BLOCK_BITS-1:0] block
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_array;
    logic [TAG_BITS-1:0]   tag_array  [LINES];
    logic [BLOCK_BITS-1:0] block_array[LINES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_array <= '0;
        end else if (write_enable) begin
            valid_array[write_index] <= 1'b1;
        end
    end

    // Tags and data are deliberately unreset: a cleared valid bit is enough
    // to make every line miss.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            tag_array[write_index]   <= write_tag;
            block_array[write_index] <= write_block;
        end
    end

    assign valid = valid_array[read_index];
    assign tag   = tag_array[read_index];
    assign block = block_array[read_index];

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache
//
// Purpose: serves 32-bit instruction words to the fetch stage and refills
// 16-byte lines from block memory, stalling the CPU during a refill.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   cpu_read            fetch request
//   cpu_address         byte address (bits [1:0] ignored), held while stalled
//   cpu_instruction     fetched word, valid while cpu_busywait is low
//   cpu_busywait        stall request to the CPU
//   mem_read            block read request
//   mem_address         block address = cpu_address[31:4]
//   mem_readdata        128-bit little-endian block
//   mem_busywait        memory busy; low marks the completing edge
//   hit_count, miss_count  access counters (only with ICACHE_PERF_COUNTERS_EN)

import icache_pkg::*;

module instruction_cache #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_read,
    input  logic [31:0]              cpu_address,
    output logic [WORD_BITS-1:0]     cpu_instruction,
    output logic                     cpu_busywait,
    output logic                     mem_read,
    output logic [MEM_ADDR_BITS-1:0] mem_address,
    input  logic [BLOCK_BITS-1:0]    mem_readdata,
    input  logic                     mem_busywait
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    state_t                  state;
    logic [OFFSET_BITS-1:0]  offset;
    logic [INDEX_BITS-1:0]   index;
    logic [TAG_BITS-1:0]     tag;
    logic                    line_valid;
    logic [TAG_BITS-1:0]     line_tag;
    logic [BLOCK_BITS-1:0]   line_block;
    logic                    hit;
    logic                    unused_byte_bits;

    assign offset           = cpu_address[3:2];
    assign index            = cpu_address[4 +: INDEX_BITS];
    assign tag              = cpu_address[31 -: TAG_BITS];
    assign unused_byte_bits = ^cpu_address[1:0];

    // Index and tag come from the live address; the CPU holds it stable
    // for the whole refill, so UPDATE writes the line that missed.
    icache_data_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_data_array (
        .clock        (clock),
        .reset        (reset),
        .read_index   (index),
        .write_enable (state == UPDATE),
        .write_index  (index),
        .write_tag    (tag),
        .write_block  (mem_readdata),
        .valid        (line_valid),
        .tag          (line_tag),
        .block        (line_block)
    );

    assign hit             = line_valid && (line_tag == tag);
    assign cpu_instruction = line_block[{offset, 5'b00000} +: WORD_BITS];
    assign cpu_busywait    = (state == IDLE) ? (cpu_read && !hit) : 1'b1;
    assign mem_address     = {tag, index};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mem_read <= 1'b0;
`ifdef ICACHE_PERF_COUNTERS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_read && !hit) begin
                        state    <= MEM_READ;
                        mem_read <= 1'b1;
`ifdef ICACHE_PERF_COUNTERS_EN
                        miss_count <= miss_count + 32'd1;
`endif
                    end
`ifdef ICACHE_PERF_COUNTERS_EN
                    else if (cpu_read) begin
                        hit_count <= hit_count + 32'd1;
                    end
`endif
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule
